// File: rtl/plab4_net_router_output_ctrl_arb_sep_if.sv
// rtl/plab4_net_router_output_ctrl_arb_sep_if.sv - request/grant/output bundle for one router output port
interface plab4_net_router_output_ctrl_arb_sep_if;
    logic       reqs_p0;
    logic       reqs_p1;
    logic       reqs_p2;
    logic       domain_p0;
    logic       domain_p1;
    logic       domain_p2;
    logic       grants_p0;
    logic       grants_p1;
    logic       grants_p2;
    logic       out_val;
    logic       out_rdy;
    logic       out_domain;
    logic [1:0] xbar_sel;

    // requester / downstream side: drives requests and ready, observes grants
    modport master (
        output reqs_p0, reqs_p1, reqs_p2,
        output domain_p0, domain_p1, domain_p2,
        output out_rdy,
        input  grants_p0, grants_p1, grants_p2,
        input  out_val, out_domain, xbar_sel
    );

    // allocator side
    modport slave (
        input  reqs_p0, reqs_p1, reqs_p2,
        input  domain_p0, domain_p1, domain_p2,
        input  out_rdy,
        output grants_p0, grants_p1, grants_p2,
        output out_val, out_domain, xbar_sel
    );
endinterface

// File: rtl/plab4_net_router_output_ctrl_arb_sep.sv
// rtl/plab4_net_router_output_ctrl_arb_sep.sv - two-domain output allocator with alternating domain pick and per-domain round-robin
module plab4_net_router_output_ctrl_arb_sep #(
    parameter int p_num_inputs = 3,
    parameter int p_cnt_nbits  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    plab4_net_router_output_ctrl_arb_sep_if.slave bus,
    output logic [p_cnt_nbits-1:0] cnt_d1,
    output logic [p_cnt_nbits-1:0] cnt_d2
);

    logic       last_dom;
    logic [1:0] ptr_d1;
    logic [1:0] ptr_d2;

    logic [2:0] reqs;
    logic [2:0] doms;
    logic [2:0] c0;
    logic [2:0] c1;
    logic       any0;
    logic       any1;
    logic       any_req;
    logic       sel_dom;
    logic [2:0] cand;
    logic [1:0] ptr;
    logic [1:0] idx0;
    logic [1:0] idx1;
    logic [1:0] idx2;
    logic [1:0] win;
    logic [2:0] win_oh;
    logic [1:0] win_next;
    logic       xfer;

    assign reqs = {bus.reqs_p2, bus.reqs_p1, bus.reqs_p0};
    assign doms = {bus.domain_p2, bus.domain_p1, bus.domain_p0};

    // Picks the domain (alternating on a tie) and the winning input inside it
    always_comb begin
        c0      = reqs & ~doms;
        c1      = reqs & doms;
        any0    = |c0;
        any1    = |c1;
        any_req = any0 | any1;
        if (any0 && any1) sel_dom = ~last_dom;
        else              sel_dom = any1;
        cand = sel_dom ? c1 : c0;
        ptr  = sel_dom ? ptr_d2 : ptr_d1;
        // scan order ptr, ptr+1, ptr+2 (all mod 3)
        idx0 = ptr;
        idx1 = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
        idx2 = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
        if      (cand[idx0]) win = idx0;
        else if (cand[idx1]) win = idx1;
        else if (cand[idx2]) win = idx2;
        else                 win = 2'd0;
        win_oh = 3'b000;
        if (any_req) begin
            case (win)
                2'd0:    win_oh = 3'b001;
                2'd1:    win_oh = 3'b010;
                default: win_oh = 3'b100;
            endcase
        end
        win_next = (win == 2'd2) ? 2'd0 : win + 2'd1;
    end

    // Drives the handshake outputs; reset forces idle with domain tag 1
    always_comb begin
        bus.out_val    = any_req & ~reset;
        xfer           = bus.out_val & bus.out_rdy;
        bus.grants_p0  = win_oh[0] & bus.out_rdy & ~reset;
        bus.grants_p1  = win_oh[1] & bus.out_rdy & ~reset;
        bus.grants_p2  = win_oh[2] & bus.out_rdy & ~reset;
        bus.xbar_sel   = bus.out_val ? win : 2'd0;
        if (reset)        bus.out_domain = 1'b1;
        else if (any_req) bus.out_domain = sel_dom;
        else              bus.out_domain = last_dom;
    end

    // Arbitration state advances only on a completed transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            last_dom <= 1'b1;
            ptr_d1   <= 2'd0;
            ptr_d2   <= 2'd0;
            cnt_d1   <= '0;
            cnt_d2   <= '0;
        end else if (xfer) begin
            last_dom <= sel_dom;
            if (sel_dom) begin
                ptr_d2 <= win_next;
                if (cnt_d2 != '1) cnt_d2 <= cnt_d2 + 1'b1;
            end else begin
                ptr_d1 <= win_next;
                if (cnt_d1 != '1) cnt_d1 <= cnt_d1 + 1'b1;
            end
        end
    end

endmodule
